tt_sweep_ctrl: RTL and testbench
================================

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 Parameter: DWELL, default 2, cycles each input vector is held before its output is sampled; legal range 1..16.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one full truth-table sweep; sampled only in IDLE.
REQ-005 abort  input  1  cancel a sweep in progress.
REQ-006 expected  input  8  golden truth table; bit i is the expected output for input vector i.
REQ-007 m_in  input  1  output of the 3-input combinational block under test.
REQ-008 a_out  output  3  input vector to the block under test; {a_out[2],a_out[1],a_out[0]} map to its three inputs.
REQ-009 busy  output  1  sweep in progress.
REQ-010 done  output  1  one-cycle pulse; results valid.
REQ-011 aborted  output  1  one-cycle pulse; sweep cancelled.
REQ-012 table_out  output  8  captured truth table; bit i is m_in sampled for vector i.
REQ-013 pass  output  1  table_out equals the latched expected value.
REQ-014 err_cnt  output  4  number of mismatching bits (0..8).
REQ-015 fail_idx  output  3  lowest mismatching vector index; 0 when pass=1.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 FSM states SHALL be IDLE, SETTLE and DONE.
REQ-018 IDLE + start=1 at edge k SHALL latch expected, clear idx and the internal capture register, load dwell counter with DWELL-1, drive a_out=0, set busy=1 and clear pass, and enter SETTLE.
REQ-019 In IDLE with start=0, the block SHALL stay in IDLE with a_out held at 0.
REQ-020 SETTLE: each vector SHALL be driven on a_out for exactly DWELL cycles.
REQ-021 SETTLE sampling: at the edge where the counter equals 0, capture[idx] SHALL take m_in.
REQ-022 SETTLE advance: at that edge, if idx<7, idx and a_out SHALL increment and the counter SHALL reload to DWELL-1.
REQ-023 SETTLE end: at that edge, if idx=7, the FSM SHALL enter DONE.
REQ-024 The sweep SHALL occupy exactly 8*DWELL cycles, with busy=1 for all of them.
REQ-025 On the edge entering DONE, the block SHALL load table_out=capture, pass=(capture==latched expected), err_cnt=popcount(capture XOR expected) and fail_idx, and SHALL set done=1 and busy=0.
REQ-026 DONE SHALL last exactly one cycle, then return to IDLE; a_out SHALL return to 0.
REQ-027 Results SHALL hold until the next accepted start; at that start only pass clears.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 start held high SHALL produce back-to-back sweeps with a period of 8*DWELL+2 cycles.
REQ-030 abort=1 in SETTLE SHALL move the FSM to IDLE on the next edge, pulse aborted=1, set busy=0 and a_out=0, and leave table_out, err_cnt and fail_idx unchanged; done SHALL NOT assert.
REQ-031 abort SHALL be ignored in IDLE and DONE; start and abort both high in IDLE starts a sweep.
REQ-032 expected changing mid-sweep SHALL have no effect on the sweep's result.

Reset
REQ-033 rst_n=0 SHALL, asynchronously and at any time including mid-sweep, force state=IDLE and set a_out, busy, done, aborted, table_out, pass, err_cnt, fail_idx, idx and the counter to 0.
REQ-034 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-035 DUT model m=(A2&A1)|A0, expected=8'hEA, DWELL=2, one start pulse -> a_out steps 0..7 every 2 cycles, busy high 16 cycles, then done pulse with table_out=8'hEA, pass=1, err_cnt=0, fail_idx=0.
REQ-036 Same model, expected=8'h6B -> table_out=8'hEA, pass=0, err_cnt=2, fail_idx=0.
REQ-037 abort asserted in the 5th busy cycle -> next cycle aborted=1, busy=0, a_out=0, no done, previous results unchanged.
REQ-038 rst_n pulsed low mid-sweep (a_out=3) -> all outputs 0 immediately, without a clock edge; a later start runs a full clean sweep.
REQ-039 start held high, DWELL=2 -> done pulses every 18 cycles, each with correct results.
REQ-040 DWELL=1 and DWELL=16 -> a_out holds each vector 1 and 16 cycles respectively; busy lasts 8 and 128 cycles; results correct.

Source files
------------

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: drives all eight input vectors of a 3-input
// block, samples its output after a dwell time and compares against a golden table.
module tt_sweep_ctrl #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       m_in,
    output logic [2:0] a_out,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [7:0] table_out,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_idx
);

    localparam logic [3:0] RELOAD = 4'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t     state, next_state;
    logic [2:0] idx, idx_d;
    logic [3:0] cnt, cnt_d;
    logic [7:0] capture, capture_d;
    logic [7:0] exp_q, exp_d;
    logic [2:0] a_out_d;
    logic       busy_d, done_d, aborted_d, pass_d;
    logic [7:0] table_d;
    logic [3:0] err_d;
    logic [2:0] fidx_d;

    logic [7:0] sampled;
    logic [7:0] mismatch;
    logic [3:0] mis_cnt;
    logic [2:0] mis_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SETTLE;
            SETTLE: begin
                if (abort)                            next_state = IDLE;
                else if (cnt == 4'd0 && idx == 3'd7)  next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The last sample lands in the same edge as the result load, so compare
    // against the capture register with the current m_in already merged in.
    always_comb begin
        sampled      = capture;
        sampled[idx] = m_in;
        mismatch     = sampled ^ exp_q;
        mis_cnt      = 4'd0;
        mis_low      = 3'd0;
        for (int i = 0; i < 8; i++) mis_cnt = mis_cnt + {3'd0, mismatch[i]};
        for (int i = 7; i >= 0; i--) if (mismatch[i]) mis_low = 3'(i);
    end

    always_comb begin
        a_out_d   = a_out;
        busy_d    = busy;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        table_d   = table_out;
        pass_d    = pass;
        err_d     = err_cnt;
        fidx_d    = fail_idx;
        idx_d     = idx;
        cnt_d     = cnt;
        capture_d = capture;
        exp_d     = exp_q;
        case (state)
            IDLE: begin
                a_out_d = 3'd0;
                if (start) begin
                    exp_d     = expected;
                    idx_d     = 3'd0;
                    capture_d = 8'd0;
                    cnt_d     = RELOAD;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    busy_d    = 1'b0;
                    a_out_d   = 3'd0;
                    aborted_d = 1'b1;
                end else if (cnt == 4'd0) begin
                    capture_d = sampled;
                    if (idx != 3'd7) begin
                        idx_d   = idx + 3'd1;
                        a_out_d = a_out + 3'd1;
                        cnt_d   = RELOAD;
                    end else begin
                        table_d = sampled;
                        pass_d  = (mismatch == 8'd0);
                        err_d   = mis_cnt;
                        fidx_d  = mis_low;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            DONE:    a_out_d = 3'd0;
            default: a_out_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out     <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            table_out <= 8'd0;
            pass      <= 1'b0;
            err_cnt   <= 4'd0;
            fail_idx  <= 3'd0;
            idx       <= 3'd0;
            cnt       <= 4'd0;
            capture   <= 8'd0;
            exp_q     <= 8'd0;
        end else begin
            a_out     <= a_out_d;
            busy      <= busy_d;
            done      <= done_d;
            aborted   <= aborted_d;
            table_out <= table_d;
            pass      <= pass_d;
            err_cnt   <= err_d;
            fail_idx  <= fidx_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            capture   <= capture_d;
            exp_q     <= exp_d;
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl at DWELL 2, 1 and 16, using m = (A2&A1)|A0
// whose truth table is 8'hEA.
module tb_tt_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] expected = 8'd0;

    logic       start_v   [3];
    logic       m_v       [3];
    logic [2:0] a_out_v   [3];
    logic       busy_v    [3];
    logic       done_v    [3];
    logic       aborted_v [3];
    logic [7:0] table_v   [3];
    logic       pass_v    [3];
    logic [3:0] err_v     [3];
    logic [2:0] fidx_v    [3];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_model
        assign m_v[g] = (a_out_v[g][2] & a_out_v[g][1]) | a_out_v[g][0];
    end

    tt_sweep_ctrl #(.DWELL(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
        .expected(expected), .m_in(m_v[0]), .a_out(a_out_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .aborted(aborted_v[0]),
        .table_out(table_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]),
        .fail_idx(fidx_v[0])
    );

    tt_sweep_ctrl #(.DWELL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
        .expected(expected), .m_in(m_v[1]), .a_out(a_out_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .aborted(aborted_v[1]),
        .table_out(table_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]),
        .fail_idx(fidx_v[1])
    );

    tt_sweep_ctrl #(.DWELL(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort),
        .expected(expected), .m_in(m_v[2]), .a_out(a_out_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .aborted(aborted_v[2]),
        .table_out(table_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]),
        .fail_idx(fidx_v[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // One full sweep on unit u; also pokes start mid-sweep and scrambles expected
    // halfway through, neither of which may disturb the result.
    task automatic applyStimulus(input int u, input int dwell, input logic [7:0] exp_word,
                                 input logic exp_pass, input logic [3:0] exp_err,
                                 input logic [2:0] exp_fidx);
        expected   = exp_word;
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
        for (int v = 0; v < 8; v++) begin
            for (int d = 0; d < dwell; d++) begin
                start_v[u] = (v == 2 && d == 0);
                if (v == 3 && d == 0) expected = ~exp_word;
                checkOutput("sweep_a_out", 32'(a_out_v[u]), 32'(v));
                checkOutput("sweep_busy", 32'(busy_v[u]), 32'd1);
                checkOutput("sweep_done", 32'(done_v[u]), 32'd0);
                @(negedge clk);
            end
        end
        start_v[u] = 1'b0;
        checkOutput("done_pulse", 32'(done_v[u]), 32'd1);
        checkOutput("done_busy", 32'(busy_v[u]), 32'd0);
        checkOutput("table_out", 32'(table_v[u]), 32'hEA);
        checkOutput("pass", 32'(pass_v[u]), 32'(exp_pass));
        checkOutput("err_cnt", 32'(err_v[u]), 32'(exp_err));
        checkOutput("fail_idx", 32'(fidx_v[u]), 32'(exp_fidx));
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done_v[u]), 32'd0);
        checkOutput("idle_a_out", 32'(a_out_v[u]), 32'd0);
        checkOutput("idle_busy", 32'(busy_v[u]), 32'd0);
    endtask

    initial begin
        int cyc;
        int last;
        int n;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

        #12;
        checkOutput("rst_a_out", 32'(a_out_v[0]), 32'd0);
        checkOutput("rst_busy", 32'(busy_v[0]), 32'd0);
        checkOutput("rst_done", 32'(done_v[0]), 32'd0);
        checkOutput("rst_table", 32'(table_v[0]), 32'd0);
        checkOutput("rst_err", 32'(err_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic sweeps, DWELL=2");
        applyStimulus(0, 2, 8'hEA, 1'b1, 4'd0, 3'd0);
        applyStimulus(0, 2, 8'h6B, 1'b0, 4'd2, 3'd0);
        applyStimulus(0, 2, 8'hE8, 1'b0, 4'd1, 3'd1);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("idle_abort_ignored", 32'(aborted_v[0]), 32'd0);
        checkOutput("idle_abort_busy", 32'(busy_v[0]), 32'd0);

        $display("[TB] abort in 5th busy cycle");
        expected   = 8'hEA;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_pre_busy", 32'(busy_v[0]), 32'd1);
        checkOutput("abort_pre_pass", 32'(pass_v[0]), 32'd0);
        checkOutput("abort_pre_a_out", 32'(a_out_v[0]), 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("aborted_pulse", 32'(aborted_v[0]), 32'd1);
        checkOutput("abort_busy", 32'(busy_v[0]), 32'd0);
        checkOutput("abort_a_out", 32'(a_out_v[0]), 32'd0);
        checkOutput("abort_done", 32'(done_v[0]), 32'd0);
        checkOutput("abort_table", 32'(table_v[0]), 32'hEA);
        checkOutput("abort_err", 32'(err_v[0]), 32'd1);
        checkOutput("abort_fidx", 32'(fidx_v[0]), 32'd1);
        @(negedge clk);
        checkOutput("aborted_one_cycle", 32'(aborted_v[0]), 32'd0);
        checkOutput("abort_no_done", 32'(done_v[0]), 32'd0);

        $display("[TB] async reset mid-sweep");
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("pre_reset_a_out", 32'(a_out_v[0]), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_a_out", 32'(a_out_v[0]), 32'd0);
        checkOutput("async_busy", 32'(busy_v[0]), 32'd0);
        checkOutput("async_table", 32'(table_v[0]), 32'd0);
        checkOutput("async_err", 32'(err_v[0]), 32'd0);
        checkOutput("async_fidx", 32'(fidx_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 2, 8'hEA, 1'b1, 4'd0, 3'd0);

        $display("[TB] start held high");
        expected   = 8'hEA;
        start_v[0] = 1'b1;
        cyc  = 0;
        last = 0;
        n    = 0;
        while (n < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done_v[0]) begin
                checkOutput("b2b_table", 32'(table_v[0]), 32'hEA);
                checkOutput("b2b_pass", 32'(pass_v[0]), 32'd1);
                if (n > 0) checkOutput("b2b_period", 32'(cyc - last), 32'd18);
                last = cyc;
                n++;
            end
        end
        start_v[0] = 1'b0;
        checkOutput("b2b_done_count", 32'(n), 32'd3);
        repeat (2) @(negedge clk);
        checkOutput("b2b_stopped", 32'(busy_v[0]), 32'd0);

        $display("[TB] DWELL=1 and DWELL=16");
        applyStimulus(1, 1, 8'hEA, 1'b1, 4'd0, 3'd0);
        applyStimulus(2, 16, 8'hAA, 1'b0, 4'd1, 3'd6);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
